// File: rtl/cbg_bank_xbar.sv
// cbg_bank_xbar: LSU-to-SRAM-bank crossbar with per-LSU pending slots and round-robin bank arbitration.
// Define CBG_CONFLICT_CNT_EN to add the per-bank saturating conflict counters on conflict_cnt.
module cbg_bank_xbar #(
  parameter int N_LSU = 4,
  parameter int N_BANK = 4,
  parameter int BS_W = 2,
  parameter int A_W = 10,
  parameter int D_W = 32,
  parameter int DEPTH = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_LSU-1:0]          lsu_ren,
  input  logic [N_LSU-1:0]          lsu_wen,
  input  logic [N_LSU*BS_W-1:0]     lsu_bank_sel,
  input  logic [N_LSU*A_W-1:0]      lsu_addr,
  input  logic [N_LSU*D_W-1:0]      lsu_wdata,
  output logic [N_LSU*(D_W+1)-1:0]  cbg_to_lsu_bus,
  output logic [N_LSU-1:0]          lsu_busy
`ifdef CBG_CONFLICT_CNT_EN
  ,output logic [N_BANK*16-1:0]     conflict_cnt
`endif
);
  localparam int LW = N_LSU > 1 ? $clog2(N_LSU) : 1;
  localparam int AI_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  function automatic int rr_idx(input int p, input int k);
    return (p + k) % N_LSU;
  endfunction
  logic [N_LSU-1:0] pend_v, pend_wr, cur_v, cur_wr, won, s1_v, out_v;
  logic [BS_W-1:0] pend_bank [N_LSU];
  logic [BS_W-1:0] cur_bank [N_LSU];
  logic [BS_W-1:0] s1_bank [N_LSU];
  logic [A_W-1:0] pend_addr [N_LSU];
  logic [A_W-1:0] cur_addr [N_LSU];
  logic [D_W-1:0] pend_wd [N_LSU];
  logic [D_W-1:0] cur_wd [N_LSU];
  logic [D_W-1:0] rdata [N_LSU];
  logic [N_BANK-1:0] gnt_v, gnt_wr;
  logic [LW-1:0] gnt_idx [N_BANK];
  logic [LW-1:0] rr_ptr [N_BANK];
  logic [AI_W-1:0] gnt_addr [N_BANK];
  logic [D_W-1:0] gnt_wd [N_BANK];
  logic [D_W-1:0] bank_q [N_BANK];
  // A valid pending slot shadows the live inputs; write wins over read when both are set.
  always_comb begin
    for (int l = 0; l < N_LSU; l++) begin
      cur_v[l] = pend_v[l] | lsu_ren[l] | lsu_wen[l];
      cur_wr[l] = pend_v[l] ? pend_wr[l] : lsu_wen[l];
      cur_bank[l] = pend_v[l] ? pend_bank[l] : lsu_bank_sel[l*BS_W +: BS_W];
      cur_addr[l] = pend_v[l] ? pend_addr[l] : lsu_addr[l*A_W +: A_W];
      cur_wd[l] = pend_v[l] ? pend_wd[l] : lsu_wdata[l*D_W +: D_W];
    end
  end
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      gnt_v[b] = 1'b0;
      gnt_idx[b] = '0;
      for (int k = 0; k < N_LSU; k++)
        if (!gnt_v[b] && cur_v[rr_idx(int'(rr_ptr[b]), k)] && cur_bank[rr_idx(int'(rr_ptr[b]), k)] == BS_W'(b)) begin
          gnt_v[b] = 1'b1;
          gnt_idx[b] = LW'(rr_idx(int'(rr_ptr[b]), k));
        end
      gnt_wr[b] = cur_wr[gnt_idx[b]];
      gnt_addr[b] = cur_addr[gnt_idx[b]][AI_W-1:0];
      gnt_wd[b] = cur_wd[gnt_idx[b]];
    end
    for (int l = 0; l < N_LSU; l++)
      won[l] = cur_v[l] && gnt_v[cur_bank[l]] && gnt_idx[cur_bank[l]] == LW'(l);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= '0;
      s1_v <= '0;
      out_v <= '0;
      for (int l = 0; l < N_LSU; l++) rdata[l] <= '0;
      for (int b = 0; b < N_BANK; b++) rr_ptr[b] <= '0;
    end else begin
      for (int l = 0; l < N_LSU; l++) begin
        if (won[l]) pend_v[l] <= 1'b0;
        else if (!pend_v[l] && cur_v[l]) begin
          pend_v[l] <= 1'b1;
          pend_wr[l] <= cur_wr[l];
          pend_bank[l] <= cur_bank[l];
          pend_addr[l] <= cur_addr[l];
          pend_wd[l] <= cur_wd[l];
        end
        s1_v[l] <= won[l] & ~cur_wr[l];
        s1_bank[l] <= cur_bank[l];
        out_v[l] <= s1_v[l];
        if (s1_v[l]) rdata[l] <= bank_q[s1_bank[l]];
      end
      for (int b = 0; b < N_BANK; b++)
        if (gnt_v[b]) rr_ptr[b] <= gnt_idx[b] == LW'(N_LSU - 1) ? '0 : gnt_idx[b] + 1'b1;
    end
  end
  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [D_W-1:0] mem [DEPTH];
    logic [D_W-1:0] q;
    always_ff @(posedge clk) begin
      if (!rst && gnt_v[b] && gnt_wr[b]) mem[gnt_addr[b]] <= gnt_wd[b];
      if (gnt_v[b] && !gnt_wr[b]) q <= mem[gnt_addr[b]];
    end
    assign bank_q[b] = q;
  end
  for (genvar l = 0; l < N_LSU; l++) begin : g_out
    assign cbg_to_lsu_bus[l*(D_W+1) +: D_W+1] = {out_v[l], rdata[l]};
  end
  assign lsu_busy = pend_v;
`ifdef CBG_CONFLICT_CNT_EN
  logic [N_BANK-1:0] multi;
  logic [15:0] ccnt [N_BANK];
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      multi[b] = 1'b0;
      for (int i = 0; i < N_LSU; i++)
        for (int j = i + 1; j < N_LSU; j++)
          if (cur_v[i] && cur_v[j] && cur_bank[i] == BS_W'(b) && cur_bank[j] == BS_W'(b)) multi[b] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++)
      if (rst) ccnt[b] <= '0;
      else if (multi[b] && ccnt[b] != 16'hFFFF) ccnt[b] <= ccnt[b] + 16'd1;
  end
  for (genvar b = 0; b < N_BANK; b++) begin : g_cc
    assign conflict_cnt[b*16 +: 16] = ccnt[b];
  end
`endif
endmodule

// File: tb/tb_cbg_bank_xbar.sv
// tb_cbg_bank_xbar: directed plan scenarios plus random traffic against a cycle-level reference model.
module tb_cbg_bank_xbar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ren, wen, busy;
  logic [7:0] bsel;
  logic [39:0] addr;
  logic [127:0] wdata;
  logic [131:0] bus;
`ifdef CBG_CONFLICT_CNT_EN
  logic [63:0] ccnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cbg_bank_xbar dut (
    .clk(clk), .rst(rst), .lsu_ren(ren), .lsu_wen(wen), .lsu_bank_sel(bsel),
    .lsu_addr(addr), .lsu_wdata(wdata), .cbg_to_lsu_bus(bus), .lsu_busy(busy)
`ifdef CBG_CONFLICT_CNT_EN
    , .conflict_cnt(ccnt)
`endif
  );
  bit m_pv [4];
  bit m_pwr [4];
  int m_pb [4];
  int m_pa [4];
  logic [31:0] m_pd [4];
  int m_ptr [4];
  int m_cc [4];
  bit e1_v [4];
  bit e2_v [4];
  logic [31:0] e1_d [4];
  logic [31:0] e2_d [4];
  logic [31:0] m_mem [4][1024];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic vld(input int l);
    return bus[l*33+32];
  endfunction
  function automatic logic [31:0] dat(input int l);
    return bus[l*33 +: 32];
  endfunction
  task automatic idle();
    ren = '0; wen = '0; bsel = '0; addr = '0; wdata = '0;
  endtask
  task automatic req(input int l, input bit r, input bit w, input int b, input int a, input logic [31:0] d);
    ren[l] = r; wen[l] = w; bsel[l*2 +: 2] = 2'(b); addr[l*10 +: 10] = 10'(a); wdata[l*32 +: 32] = d;
  endtask
  // One clock: model decides grants from the pre-edge view, then DUT outputs are compared after the edge.
  task automatic cycle();
    bit rv [4];
    bit rw [4];
    int rb [4];
    int ra [4];
    logic [31:0] rd [4];
    int win [4];
    int nc [4];
    int idx;
    for (int l = 0; l < 4; l++) begin
      rv[l] = m_pv[l] || ren[l] || wen[l];
      rw[l] = m_pv[l] ? m_pwr[l] : wen[l];
      rb[l] = m_pv[l] ? m_pb[l] : int'(bsel[l*2 +: 2]);
      ra[l] = m_pv[l] ? m_pa[l] : int'(addr[l*10 +: 10]);
      rd[l] = m_pv[l] ? m_pd[l] : wdata[l*32 +: 32];
    end
    for (int b = 0; b < 4; b++) begin
      win[b] = -1;
      nc[b] = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr[b] + k) % 4;
        if (rv[idx] && rb[idx] == b) begin
          nc[b]++;
          if (win[b] < 0) win[b] = idx;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pv[i] = 0; m_ptr[i] = 0; m_cc[i] = 0;
        e1_v[i] = 0; e2_v[i] = 0; e2_d[i] = '0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        e2_v[l] = e1_v[l];
        if (e1_v[l]) e2_d[l] = e1_d[l];
        e1_v[l] = 0;
      end
      for (int b = 0; b < 4; b++) begin
        if (nc[b] >= 2 && m_cc[b] < 65535) m_cc[b]++;
        if (win[b] >= 0) begin
          m_ptr[b] = (win[b] + 1) % 4;
          if (rw[win[b]]) m_mem[b][ra[win[b]]] = rd[win[b]];
          else begin
            e1_v[win[b]] = 1;
            e1_d[win[b]] = m_mem[b][ra[win[b]]];
          end
        end
      end
      for (int l = 0; l < 4; l++) begin
        if (rv[l] && win[rb[l]] == l) m_pv[l] = 0;
        else if (rv[l] && !m_pv[l]) begin
          m_pv[l] = 1; m_pwr[l] = rw[l]; m_pb[l] = rb[l]; m_pa[l] = ra[l]; m_pd[l] = rd[l];
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      chk("read_valid", vld(l), e2_v[l]);
      chk("rdata", dat(l), e2_d[l]);
      chk("busy", busy[l], m_pv[l]);
    end
`ifdef CBG_CONFLICT_CNT_EN
    for (int b = 0; b < 4; b++) chk("conflict_cnt", ccnt[b*16 +: 16], 64'(m_cc[b]));
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int run [2];
    int mx [2];
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("rst_busy", busy, 0);
    for (int l = 0; l < 4; l++) begin
      chk("rst_vld", vld(l), 0);
      chk("rst_dat", dat(l), 0);
    end
    for (int a = 0; a < 16; a++) begin
      for (int l = 0; l < 4; l++) req(l, 0, 1, l, a, $urandom);
      cycle();
    end
    idle();
    // single write then read
    req(0, 0, 1, 1, 5, 32'hDEADBEEF);
    cycle();
    idle();
    cycle();
    req(0, 1, 0, 1, 5, 0);
    cycle();
    idle();
    cycle();
    chk("t1_vld0", vld(0), 1);
    chk("t1_dat0", dat(0), 32'hDEADBEEF);
    for (int l = 1; l < 4; l++) chk("t1_vld_other", vld(l), 0);
    // four-way conflict on bank 2 from cleared pointers
    for (int a = 0; a < 4; a++) begin
      req(0, 0, 1, 2, a, 32'h10 + a);
      cycle();
    end
    idle();
    rst = 1;
    cycle();
    rst = 0;
    for (int l = 0; l < 4; l++) req(l, 1, 0, 2, l, 0);
    cycle();
    idle();
    for (int c = 1; c <= 6; c++) begin
      chk("t2_busy3", busy[3], c <= 3);
      for (int l = 0; l < 4; l++) chk("t2_vld", vld(l), c == l + 2);
      if (c >= 2 && c <= 5) chk("t2_dat", dat(c - 2), 32'h10 + c - 2);
      cycle();
    end
`ifdef CBG_CONFLICT_CNT_EN
    chk("t2_ccnt_bank2", ccnt[47:32], 3);
`endif
    // parallel, conflict-free reads
    for (int l = 0; l < 4; l++) req(l, 1, 0, l, l, 0);
    cycle();
    idle();
    for (int c = 1; c <= 3; c++) begin
      chk("t3_busy", busy, 0);
      if (c == 2) for (int l = 0; l < 4; l++) chk("t3_vld", vld(l), 1);
      cycle();
    end
    // two LSUs streaming to bank 0
    run[0] = 0; run[1] = 0; mx[0] = 0; mx[1] = 0;
    for (int i = 0; i < 20; i++) begin
      for (int l = 0; l < 2; l++)
        if (!busy[l]) req(l, 1, 0, 0, l, 0);
        else ren[l] = 0;
      cycle();
      for (int l = 0; l < 2; l++) begin
        run[l] = busy[l] ? run[l] + 1 : 0;
        if (run[l] > mx[l]) mx[l] = run[l];
      end
    end
    idle();
    chk("t4_wait0", mx[0], 1);
    chk("t4_wait1", mx[1], 1);
    repeat (3) cycle();
    // read+write together behaves as write
    req(2, 1, 1, 3, 7, 32'h55);
    cycle();
    idle();
    for (int c = 1; c <= 3; c++) begin
      chk("t5_novld", vld(2), 0);
      cycle();
    end
    req(2, 1, 0, 3, 7, 0);
    cycle();
    idle();
    cycle();
    chk("t5_vld", vld(2), 1);
    chk("t5_dat", dat(2), 32'h55);
    // reset while a read is in flight
    req(1, 1, 0, 1, 3, 0);
    cycle();
    idle();
    rst = 1;
    cycle();
    rst = 0;
    for (int l = 0; l < 4; l++) chk("t6_novld", vld(l), 0);
    chk("t6_busy", busy, 0);
    req(1, 1, 0, 1, 3, 0);
    cycle();
    idle();
    cycle();
    chk("t6_vld", vld(1), 1);
    chk("t6_dat", dat(1), m_mem[1][3]);
    // random traffic
    repeat (400) begin
      idle();
      for (int l = 0; l < 4; l++)
        if ($urandom % 4 != 0)
          req(l, 1'($urandom % 2), $urandom % 3 == 0, int'($urandom % 4), int'($urandom % 16), $urandom);
      rst = ($urandom % 80 == 0);
      cycle();
    end
    rst = 0;
    idle();
    repeat (6) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
